ppu_stream: RTL and testbench

- Parametrised pixel-processing unit between the pixel source (e.g. SPI/bus loader) and the VGA scan-out path.
- Accepts pixels on a valid/ready input stream into an internal FIFO.
- Emits one output pixel per transfer on a valid/ready output stream, tracking raster position (h, v) over an H_PIX x V_PIX frame.
- Output is pass-through, masked, or generated by a mode-selected pattern; animated modes use a frame counter.

---
 rtl/ppu_stream.sv | 135 +++++++++++++
 tb/tb_ppu_stream.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_stream.sv
// ppu_stream: pixel stream processor (input FIFO, raster-tracked output, pattern modes).
// Define PPU_FREERUN_EN to start each new frame immediately instead of waiting for frame_sync.
module ppu_stream #(
   parameter int DATA_W     = 8,
   parameter int H_PIX      = 32,
   parameter int V_PIX      = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int FCNT_W     = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              frame_sync,
   input  logic [2:0]        mode,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sof,
   output logic              out_eol,
   output logic [FCNT_W-1:0] frame_cnt
);
   localparam int HW = $clog2(H_PIX);
   localparam int VW = $clog2(V_PIX);
   localparam int XW = HW > VW ? HW : VW;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int UH = DATA_W / 2;
   localparam int LH = DATA_W - UH;
   localparam logic [HW-1:0] H_LAST = HW'(H_PIX - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_PIX - 1);

   typedef enum logic {WAIT_SYNC, RUN} state_t;

   state_t              state, state_n;
   logic [HW-1:0]       h, h_n;
   logic [VW-1:0]       v, v_n, vf;
   logic [FCNT_W-1:0]   fcnt_n;
   logic                sync_q, sync_edge;
   logic [DATA_W-1:0]   mem [FIFO_DEPTH];
   logic [AW-1:0]       rptr, wptr;
   logic [AW:0]         cnt;
   logic                empty, push, pop, uses_fifo, load, h_end, v_end;
   logic [XW-1:0]       x, y;
   logic [DATA_W-1:0]   head, pix;

   function automatic logic div7(input logic [XW-1:0] a);
      return 32'(a) % 32'd7 == 32'd0;
   endfunction

   assign sync_edge = frame_sync && !sync_q;
   assign head      = mem[rptr];
   assign empty     = cnt == '0;
   assign in_ready  = !cnt[AW];
   assign push      = in_valid && in_ready;
   assign uses_fifo = mode <= 3'd1;
   assign load      = (!out_valid || out_ready) && state == RUN && !(uses_fifo && empty);
   assign pop       = load && uses_fifo;
   assign h_end     = h == H_LAST;
   assign v_end     = v == V_LAST;
   assign x         = XW'(h) ^ XW'(v);
   assign vf        = v + VW'(frame_cnt);
   assign y         = XW'(vf) ^ XW'(h);

   always_comb begin
      pix = mode == 3'd0 ? head :
            mode == 3'd1 ? (x != '0 ? head : '0) :
            mode == 3'd2 ? {DATA_W{x == '0}} :
            mode == 3'd3 ? {DATA_W{div7(x)}} :
            mode == 3'd4 ? {{UH{div7(y)}}, {LH{div7(x)}}} : '0;
   end

   // a sync edge overrides any end-of-frame advance in the same cycle
   always_comb begin
      state_n = state;
      h_n     = h;
      v_n     = v;
      fcnt_n  = frame_cnt;
      if (load) begin
         h_n = h_end ? '0 : h + 1'b1;
         v_n = !h_end ? v : v_end ? '0 : v + 1'b1;
         if (h_end && v_end) begin
`ifdef PPU_FREERUN_EN
            fcnt_n = frame_cnt + 1'b1;
`else
            state_n = WAIT_SYNC;
`endif
         end
      end
      if (sync_edge) begin
         state_n = RUN;
         h_n     = '0;
         v_n     = '0;
         fcnt_n  = frame_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= WAIT_SYNC;
         h         <= '0;
         v         <= '0;
         frame_cnt <= '0;
         sync_q    <= 1'b0;
         rptr      <= '0;
         wptr      <= '0;
         cnt       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         out_sof   <= 1'b0;
         out_eol   <= 1'b0;
      end else begin
         state     <= state_n;
         h         <= h_n;
         v         <= v_n;
         frame_cnt <= fcnt_n;
         sync_q    <= frame_sync;
         cnt       <= cnt + (AW+1)'(push) - (AW+1)'(pop);
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= pix;
            out_sof   <= h == '0 && v == '0;
            out_eol   <= h_end;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr] <= in_data;
   end
endmodule

// File: tb/tb_ppu_stream.sv
// tb_ppu_stream: directed bench for ppu_stream on a 4x4 raster with a 4-entry FIFO.
module tb_ppu_stream;
   typedef struct packed {logic [7:0] d; logic sof; logic eol;} beat_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       frame_sync = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [7:0] in_data = 8'h00;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic       out_sof, out_eol;
   logic [7:0] frame_cnt;

   int    checks = 0;
   int    failures = 0;
   int    eh = 0, ev = 0, efc = 0;
   beat_t q[$];
   beat_t held;

   ppu_stream #(.DATA_W(8), .H_PIX(4), .V_PIX(4), .FIFO_DEPTH(4), .FCNT_W(8)) dut (
      .clk(clk), .rst(rst), .frame_sync(frame_sync), .mode(mode),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sof(out_sof), .out_eol(out_eol), .frame_cnt(frame_cnt));

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_pix(int m, int hh, int vv, int fc, logic [7:0] hd);
      int xx = hh ^ vv;
      int yy = ((vv + fc) % 4) ^ hh;
      case (m)
         0: return hd;
         1: return xx != 0 ? hd : 8'h00;
         2: return hh == vv ? 8'hFF : 8'h00;
         3: return xx % 7 == 0 ? 8'hFF : 8'h00;
         4: return {(yy % 7 == 0) ? 4'hF : 4'h0, (xx % 7 == 0) ? 4'hF : 4'h0};
         default: return 8'h00;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_beat(input logic [7:0] hd);
      beat_t b;
      b.d = exp_pix(int'(mode), eh, ev, efc, hd);
      b.sof = (eh == 0 && ev == 0);
      b.eol = (eh == 3);
      q.push_back(b);
      eh++;
      if (eh == 4) begin
         eh = 0;
         ev = (ev + 1) % 4;
      end
   endtask

   task automatic expect_n(input int n);
      for (int i = 0; i < n; i++) expect_beat(8'h00);
   endtask

   // monitor transfers on the falling edge, then step past the next rising edge
   task automatic cyc();
      beat_t e;
      @(negedge clk);
      if (out_valid && out_ready) begin
         checks++;
         assert (q.size() != 0) else begin
            failures++;
            $error("FAIL unexpected_beat observed=%0h expected=none", out_data);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("beat_data", out_data, e.d);
            chk("beat_sof", out_sof, e.sof);
            chk("beat_eol", out_eol, e.eol);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         cyc();
         n++;
      end
      chk("drain_left", q.size(), 0);
   endtask

   task automatic sync_pulse();
      frame_sync = 1'b1;
      cyc();
      frame_sync = 1'b0;
      efc++;
      eh = 0;
      ev = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sof", out_sof, 0);
      chk("rst_out_eol", out_eol, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_in_ready", in_ready, 1);

      out_ready = 1'b1;
      sync_pulse();
      repeat (3) cyc();
      chk("idle_out_valid", out_valid, 0);
      chk("idle_frame_cnt", frame_cnt, 1);
      chk("idle_in_ready", in_ready, 1);

      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data = 8'h11 * (i + 1);
         expect_beat(in_data);
         cyc();
         if (i == 0) chk("pass_latency", out_valid, 0);
      end
      in_valid = 1'b0;
      drain();

      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         in_data = 8'h55 + 8'h11 * i;
         expect_beat(in_data);
         cyc();
      end
      chk("full_in_ready", in_ready, 0);
      chk("full_held_data", out_data, 8'h55);
      in_data = 8'hEE;
      cyc();
      in_valid = 1'b0;
      out_ready = 1'b1;
      drain();
      repeat (3) cyc();

`ifndef PPU_FREERUN_EN
      mode = 3'd2;
      expect_n(7);
      drain();
      repeat (3) cyc();
      chk("eof_wait_valid", out_valid, 0);
      sync_pulse();
      expect_n(16);
      drain();
      repeat (3) cyc();
      chk("diag_done_valid", out_valid, 0);
      chk("diag_frame_cnt", frame_cnt, 2);

      mode = 3'd4;
      sync_pulse();
      expect_n(6);
      repeat (6) cyc();
      out_ready = 1'b0;
      frame_sync = 1'b1;
      cyc();
      frame_sync = 1'b0;
      chk("abort_frame_cnt", frame_cnt, 4);
      chk("abort_held_valid", out_valid, 1);
      chk("abort_queue", q.size(), 1);
      chk("abort_held_data", out_data, q[0].d);
      efc = 4;
      eh = 0;
      ev = 0;
      mode = 3'd3;
      expect_n(16);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      chk("restart_sof", out_sof, 1);
      held = '{out_data, out_sof, out_eol};
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("hold_valid", out_valid, 1);
         chk("hold_beat", {out_data, out_sof, out_eol}, held);
      end
      out_ready = 1'b1;
      drain();
      repeat (2) cyc();
      chk("bp_done_valid", out_valid, 0);
      chk("bp_frame_cnt", frame_cnt, 4);

      mode = 3'd1;
      sync_pulse();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_data = 8'hA1 + 8'h11 * i;
         expect_beat(in_data);
         cyc();
      end
      in_valid = 1'b0;
      drain();
      mode = 3'd5;
      expect_n(12);
      drain();
      repeat (2) cyc();
      chk("mask_done_valid", out_valid, 0);
      chk("mask_frame_cnt", frame_cnt, 5);
`else
      mode = 3'd5;
      expect_n(39);
      drain();
      out_ready = 1'b0;
      chk("free_frame_cnt", frame_cnt, 4);
      chk("free_valid", out_valid, 1);
`endif

      #2;
      rst = 1'b1;
      #2;
      chk("arst_frame_cnt", frame_cnt, 0);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_in_ready", in_ready, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
